// File: rtl/fence_sequencer_pkg.sv
// Shared fence encodings and sequencer state encoding, also used by the decoder.
// No logic; constants, types and one helper only.
// Not applicable: there is no flow control in a package.
package fence_sequencer_pkg;

    localparam logic [1:0] FENCE_T_FENCE  = 2'b00;
    localparam logic [1:0] FENCE_T_FENCEI = 2'b01;
    localparam logic [1:0] FENCE_T_SFENCE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_ICINV = 3'd2,
        ST_TLBFL = 3'd3,
        ST_REDIR = 3'd4,
        ST_DONE  = 3'd5
    } fence_state_t;

    // Where a drained fence goes next; type 2'b11 behaves as a plain FENCE.
    function automatic fence_state_t drain_exit_state(input logic [1:0] ftype);
        case (ftype)
            FENCE_T_FENCEI: return ST_ICINV;
            FENCE_T_SFENCE: return ST_TLBFL;
            default:        return ST_DONE;
        endcase
    endfunction

endpackage

// File: rtl/fence_wait_timer.sv
// 8-bit wait counter with clear/enable and an elapsed-cycles >= threshold flag.
// Flag is combinational from the count register and the threshold input.
// No backpressure; the count saturates at 255 instead of wrapping.
module fence_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] threshold,
    output logic       reached
);

    logic [7:0] count;

    // Count cycles spent in the current state; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    // The count holds cycles already completed, so +1 includes the current one.
    always_comb begin
        reached = (({1'b0, count} + 9'd1) >= {1'b0, threshold});
    end

endmodule

// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA: drain, invalidate or flush, redirect, release.
// Plain FENCE on idle pipeline completes DRAIN_MIN+1 cycles after detection.
// Holds IF/ID via fence_stall; waits on mem/store-buffer drain and on cache/TLB acks.
module fence_sequencer
    import fence_sequencer_pkg::*;
#(
    parameter int DRAIN_MIN = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fence_valid,
    input  logic [1:0]  fence_type,
    input  logic [31:0] fence_pc,
    input  logic        trap_flush,
    input  logic        mem_busy,
    input  logic        sb_empty,
    input  logic        icache_inv_ack,
    input  logic        tlb_flush_ack,
    output logic        fence_stall,
    output logic        icache_inv_req,
    output logic        tlb_flush_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        fence_done,
    output logic        fence_timeout
);

    localparam logic [7:0] DRAIN_THR   = DRAIN_MIN[7:0];
    localparam logic [7:0] TIMEOUT_THR = TIMEOUT[7:0];

    fence_state_t state_q, state_d;
    logic [1:0]   type_q;
    logic [31:0]  pc_q;
    logic         tmo_q, tmo_d;
    logic         latch;
    logic         tmr_clr, tmr_en, tmr_reached;
    logic [7:0]   tmr_thr;

    // One timer serves both the drain minimum and the ack wait limit.
    always_comb begin
        tmr_thr = (state_q == ST_DRAIN) ? DRAIN_THR : TIMEOUT_THR;
    end

    fence_wait_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .threshold (tmr_thr),
        .reached   (tmr_reached)
    );

    // State, latched fence and timeout marker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            type_q  <= FENCE_T_FENCE;
            pc_q    <= 32'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (latch) begin
                type_q <= fence_type;
                pc_q   <= fence_pc;
            end
        end
    end

    // Next state, timer control and the stall; trap_flush overrides everything.
    always_comb begin
        state_d     = state_q;
        tmo_d       = 1'b0;
        latch       = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        fence_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Combinational so decode already holds in the detect cycle.
                fence_stall = fence_valid;
                tmr_clr     = 1'b1;
                if (fence_valid && !trap_flush) begin
                    latch   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                fence_stall = 1'b1;
                tmr_en      = 1'b1;
                if (trap_flush) begin
                    state_d = ST_IDLE;
                end else if (tmr_reached && !mem_busy && sb_empty) begin
                    state_d = drain_exit_state(type_q);
                end
            end
            ST_ICINV: begin
                fence_stall = 1'b1;
                tmr_en      = 1'b1;
                if (trap_flush) begin
                    state_d = ST_IDLE;
                end else if (icache_inv_ack) begin
                    state_d = ST_REDIR;
                end else if (tmr_reached) begin
                    state_d = ST_REDIR;
                    tmo_d   = 1'b1;
                end
            end
            ST_TLBFL: begin
                fence_stall = 1'b1;
                tmr_en      = 1'b1;
                if (trap_flush) begin
                    state_d = ST_IDLE;
                end else if (tlb_flush_ack) begin
                    state_d = ST_REDIR;
                end else if (tmr_reached) begin
                    state_d = ST_REDIR;
                    tmo_d   = 1'b1;
                end
            end
            ST_REDIR: begin
                fence_stall = 1'b1;
                state_d     = trap_flush ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                // fence_valid is deliberately ignored here; decode consumes it now.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Every state starts counting from zero.
        if (state_d != state_q) begin
            tmr_clr = 1'b1;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        icache_inv_req = (state_q == ST_ICINV);
        tlb_flush_req  = (state_q == ST_TLBFL);
        redirect_valid = (state_q == ST_REDIR);
        redirect_pc    = (state_q == ST_REDIR) ? (pc_q + 32'd4) : 32'd0;
        fence_done     = (state_q == ST_DONE);
        fence_timeout  = (state_q == ST_REDIR) && tmo_q;
    end

endmodule

// File: tb/tb_fence_sequencer.sv
module tb_fence_sequencer;

    localparam int DMIN = 2;
    localparam int TMO  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        fence_valid;
    logic [1:0]  fence_type;
    logic [31:0] fence_pc;
    logic        trap_flush, mem_busy, sb_empty, icache_inv_ack, tlb_flush_ack;
    logic        fence_stall, icache_inv_req, tlb_flush_req, redirect_valid;
    logic [31:0] redirect_pc;
    logic        fence_done, fence_timeout;

    fence_sequencer #(.DRAIN_MIN(DMIN), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .fence_valid    (fence_valid),
        .fence_type     (fence_type),
        .fence_pc       (fence_pc),
        .trap_flush     (trap_flush),
        .mem_busy       (mem_busy),
        .sb_empty       (sb_empty),
        .icache_inv_ack (icache_inv_ack),
        .tlb_flush_ack  (tlb_flush_ack),
        .fence_stall    (fence_stall),
        .icache_inv_req (icache_inv_req),
        .tlb_flush_req  (tlb_flush_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fence_done     (fence_done),
        .fence_timeout  (fence_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural model: where the fence is in its life and how long it has been there.
    localparam int P_IDLE = 0, P_DRAIN = 1, P_WAIT = 2, P_REDIR = 3, P_DONE = 4;
    int          m_phase;
    int          m_elapsed;
    logic [1:0]  m_kind;
    logic [31:0] m_pc;
    bit          m_tmo;
    bit          m_consumed;

    // Event log of observed DUT outputs for the directed scenarios.
    int          rec_done_n, rec_done_cyc, rec_redir_n, rec_redir_cyc, rec_tmo_cyc;
    int          rec_req_first, rec_req_last, rec_req_rises, rec_stall_n;
    logic [31:0] rec_rpc;
    bit          prev_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_elapsed = 0; m_kind = 2'b00; m_pc = 32'd0;
        m_tmo = 1'b0; m_consumed = 1'b0; prev_req = 1'b0;
    endtask

    task automatic clear_rec();
        rec_done_n = 0; rec_done_cyc = -1; rec_redir_n = 0; rec_redir_cyc = -1;
        rec_tmo_cyc = -1; rec_req_first = -1; rec_req_last = -1; rec_req_rises = 0;
        rec_stall_n = 0; rec_rpc = 32'hDEADBEEF; prev_req = 1'b0;
    endtask

    task automatic model_compare();
        bit req;
        chk("fence_stall", fence_stall,
            (m_phase == P_IDLE) ? fence_valid : (m_phase != P_DONE));
        chk("icache_inv_req", icache_inv_req, (m_phase == P_WAIT) && (m_kind == 2'b01));
        chk("tlb_flush_req", tlb_flush_req, (m_phase == P_WAIT) && (m_kind == 2'b10));
        chk("redirect_valid", redirect_valid, m_phase == P_REDIR);
        chk("redirect_pc", redirect_pc, (m_phase == P_REDIR) ? m_pc + 32'd4 : 32'd0);
        chk("fence_done", fence_done, m_phase == P_DONE);
        chk("fence_timeout", fence_timeout, (m_phase == P_REDIR) && m_tmo);
        req = icache_inv_req | tlb_flush_req;
        if (req && rec_req_first < 0) rec_req_first = cyc;
        if (req) rec_req_last = cyc;
        if (req && !prev_req) rec_req_rises++;
        prev_req = req;
        if (fence_done) begin rec_done_n++; rec_done_cyc = cyc; end
        if (redirect_valid) begin rec_redir_n++; rec_redir_cyc = cyc; rec_rpc = redirect_pc; end
        if (fence_timeout) rec_tmo_cyc = cyc;
        if (fence_stall) rec_stall_n++;
    endtask

    task automatic model_advance();
        bit ack;
        m_consumed = fence_valid && (trap_flush || m_phase == P_DONE);
        if (m_phase != P_IDLE && trap_flush) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: if (fence_valid && !trap_flush) begin
                    m_phase = P_DRAIN; m_elapsed = 0; m_kind = fence_type; m_pc = fence_pc;
                end
                P_DRAIN: begin
                    if (m_elapsed + 1 >= DMIN && !mem_busy && sb_empty) begin
                        m_phase   = (m_kind == 2'b01 || m_kind == 2'b10) ? P_WAIT : P_DONE;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
                P_WAIT: begin
                    ack = (m_kind == 2'b01) ? icache_inv_ack : tlb_flush_ack;
                    if (ack) begin
                        m_phase = P_REDIR; m_tmo = 1'b0;
                    end else if (m_elapsed + 1 >= TMO) begin
                        m_phase = P_REDIR; m_tmo = 1'b1;
                    end else begin
                        m_elapsed++;
                    end
                end
                P_REDIR: m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
        end
        if (m_phase != P_REDIR) m_tmo = 1'b0;
    endtask

    // Inputs are set by the caller after posedge+1; outputs checked at negedge.
    task automatic tick();
        @(negedge clk);
        model_compare();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet_inputs();
        fence_valid = 1'b0; fence_type = 2'b00; fence_pc = 32'd0; trap_flush = 1'b0;
        mem_busy = 1'b0; sb_empty = 1'b1; icache_inv_ack = 1'b0; tlb_flush_ack = 1'b0;
    endtask

    task automatic start_fence(input logic [1:0] t, input logic [31:0] pc);
        quiet_inputs();
        clear_rec();
        cyc = 0;
        fence_type = t;
        fence_pc   = pc;
    endtask

    initial begin
        quiet_inputs();
        model_reset();
        clear_rec();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", fence_stall, 1'b0);
        chk("reset_done", fence_done, 1'b0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Plain FENCE on an idle pipeline.
        start_fence(2'b00, 32'h0000_0040);
        for (int c = 0; c < 6; c++) begin
            fence_valid = (c <= 3);
            tick();
        end
        chk("t1_done_cycle", rec_done_cyc, 3);
        chk("t1_done_count", rec_done_n, 1);
        chk("t1_no_redirect", rec_redir_n, 0);
        chk("t1_stall_cycles", rec_stall_n, 3);

        // FENCE.I with ack four cycles after the request; stray acks ignored.
        start_fence(2'b01, 32'h0000_0100);
        for (int c = 0; c < 12; c++) begin
            fence_valid    = (c <= 9);
            icache_inv_ack = (c == 1) || (c == 7);
            tlb_flush_ack  = (c == 4);
            tick();
        end
        chk("t2_req_first", rec_req_first, 3);
        chk("t2_req_last", rec_req_last, 7);
        chk("t2_req_bursts", rec_req_rises, 1);
        chk("t2_redirect_cycle", rec_redir_cyc, 8);
        chk("t2_redirect_pc", rec_rpc, 32'h0000_0104);
        chk("t2_done_cycle", rec_done_cyc, 9);

        // SFENCE.VMA behind a busy memory pipe, ack never arrives.
        start_fence(2'b10, 32'h0000_2000);
        for (int c = 0; c < 268; c++) begin
            fence_valid = (c <= 263);
            mem_busy    = (c < 6);
            tick();
        end
        chk("t3_req_first", rec_req_first, 7);
        chk("t3_req_last", rec_req_last, 261);
        chk("t3_timeout_cycle", rec_tmo_cyc, 262);
        chk("t3_redirect_cycle", rec_redir_cyc, 262);
        chk("t3_done_cycle", rec_done_cyc, 263);

        // Trap in ICINV coinciding with the ack.
        start_fence(2'b01, 32'h0000_0300);
        for (int c = 0; c < 9; c++) begin
            fence_valid    = (c <= 4);
            icache_inv_ack = (c == 4);
            trap_flush     = (c == 4);
            tick();
        end
        chk("t4_req_last", rec_req_last, 4);
        chk("t4_no_redirect", rec_redir_n, 0);
        chk("t4_no_done", rec_done_n, 0);
        chk("t4_stall_cycles", rec_stall_n, 5);

        // FENCE.I at the top of the address space; fence_valid held through DONE.
        start_fence(2'b01, 32'hFFFF_FFFC);
        for (int c = 0; c < 10; c++) begin
            fence_valid    = (c <= 5);
            icache_inv_ack = (c == 3);
            tick();
        end
        chk("t5_redirect_pc_wrap", rec_rpc, 32'h0000_0000);
        chk("t5_redirect_cycle", rec_redir_cyc, 4);
        chk("t5_done_cycle", rec_done_cyc, 5);
        chk("t5_single_done", rec_done_n, 1);
        chk("t5_single_req", rec_req_rises, 1);

        // Asynchronous reset in the middle of a TLB flush.
        start_fence(2'b10, 32'h0000_0500);
        fence_valid = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("t6_in_tlbfl", tlb_flush_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_tlb_req", tlb_flush_req, 1'b0);
        chk("t6_rst_ic_req", icache_inv_req, 1'b0);
        chk("t6_rst_redirect", redirect_valid, 1'b0);
        chk("t6_rst_done", fence_done, 1'b0);
        chk("t6_rst_timeout", fence_timeout, 1'b0);
        chk("t6_rst_stall_idle_rule", fence_stall, 1'b1);
        fence_valid = 1'b0;
        #1;
        chk("t6_rst_stall_low", fence_stall, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tick();

        // Randomised traffic against the model.
        quiet_inputs();
        for (int i = 0; i < 4000; i++) begin
            if (m_consumed) begin
                fence_valid = 1'b0;
            end else if (!fence_valid && $urandom_range(3) == 0) begin
                fence_valid = 1'b1;
                fence_type  = 2'($urandom_range(3));
                fence_pc    = $urandom;
            end
            mem_busy       = ($urandom_range(2) == 0);
            sb_empty       = ($urandom_range(3) != 0);
            icache_inv_ack = ($urandom_range(7) == 0);
            tlb_flush_ack  = ($urandom_range(7) == 0);
            trap_flush     = ($urandom_range(63) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
